// File: rtl/stacker_pkg.sv
// rtl/stacker_pkg.sv - shared colour codes, FSM states and RGB widths for the stack renderer
package stacker_pkg;

  localparam int RED_W   = 3;
  localparam int GREEN_W = 3;
  localparam int BLUE_W  = 2;
  localparam int RGB_W   = RED_W + GREEN_W + BLUE_W;

  localparam logic [1:0] CLR_NONE  = 2'b00;
  localparam logic [1:0] CLR_GREEN = 2'b01;
  localparam logic [1:0] CLR_RED   = 2'b10;
  localparam logic [1:0] CLR_BLUE  = 2'b11;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_CLEARING = 1'b1
  } state_t;

  typedef logic signed [10:0] coord_t;

  // Packed as {red, green, blue}; each lit channel is driven to full scale.
  function automatic logic [RGB_W-1:0] decode_clr(input logic [1:0] code);
    logic [RGB_W-1:0] rgb;
    rgb = '0;
    case (code)
      CLR_RED:   rgb = {{RED_W{1'b1}}, {GREEN_W{1'b0}}, {BLUE_W{1'b0}}};
      CLR_GREEN: rgb = {{RED_W{1'b0}}, {GREEN_W{1'b1}}, {BLUE_W{1'b0}}};
      CLR_BLUE:  rgb = {{RED_W{1'b0}}, {GREEN_W{1'b0}}, {BLUE_W{1'b1}}};
      default:   rgb = '0;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/block_hit.sv
// rtl/block_hit.sv - strict-bounds hit test of one BLK_W x BLK_H box plus its colour decode
module block_hit
  import stacker_pkg::*;
#(
  parameter int CLR_W = 2,
  parameter int BLK_W = 100,
  parameter int BLK_H = 20
) (
  input  logic [9:0]       x_i,
  input  logic [9:0]       y_i,
  input  coord_t           lo_x_i,
  input  coord_t           lo_y_i,
  input  logic [CLR_W-1:0] clr_i,
  output logic             hit_o,
  output logic [RGB_W-1:0] rgb_o
);

  localparam logic signed [11:0] W12 = 12'(BLK_W);
  localparam logic signed [11:0] H12 = 12'(BLK_H);

  // One guard bit above the 11-bit coordinates so lo + size cannot wrap.
  logic signed [11:0] px, py, lx, ly, hx, hy;

  assign px = {2'b00, x_i};
  assign py = {2'b00, y_i};
  assign lx = {lo_x_i[10], lo_x_i};
  assign ly = {lo_y_i[10], lo_y_i};
  assign hx = lx + W12;
  assign hy = ly + H12;

  assign hit_o = (clr_i != '0) && (lx < px) && (px < hx) && (ly < py) && (py < hy);
  assign rgb_o = decode_clr(clr_i[1:0]);

endmodule

// File: rtl/stack_renderer.sv
// rtl/stack_renderer.sv - colour-block stack with push/clear control and a 2-cycle pixel renderer
module stack_renderer
  import stacker_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int CLR_W  = 2,
  parameter int BLK_W  = 100,
  parameter int BLK_H  = 20,
  parameter int BASE_Y = 400,
  parameter int SCROLL = 1
) (
  input  logic                       dclk,
  input  logic                       rst,
  input  logic [9:0]                 x,
  input  logic [9:0]                 y,
  input  logic                       frame_start,
  input  logic [9:0]                 pos_x,
  input  logic                       push_valid,
  output logic                       push_ready,
  input  logic [CLR_W-1:0]           push_clr,
  input  logic                       clear,
  input  logic [9:0]                 fall_x,
  input  logic [9:0]                 fall_y,
  input  logic [CLR_W-1:0]           fall_clr,
  output logic [$clog2(DEPTH+1)-1:0] height,
  output logic                       full,
  output logic [RED_W-1:0]           RED,
  output logic [GREEN_W-1:0]         GREEN,
  output logic [BLUE_W-1:0]          BLUE
);

  localparam int HW = $clog2(DEPTH+1);

  state_t           state_q;
  logic [HW-1:0]    height_q;
  logic [CLR_W-1:0] rows_q   [DEPTH];
  logic [CLR_W-1:0] shadow_q [DEPTH];
  logic [9:0]       shpos_q;

  logic [9:0]       x_q, y_q, fx_q, fy_q;
  logic [CLR_W-1:0] fclr_q;
  logic [RGB_W-1:0] rgb_q, rgb_d;

  logic             push_fire;

  assign full       = (height_q == HW'(DEPTH));
  assign push_ready = (state_q == ST_RUN) && !(full && (SCROLL == 0));
  assign push_fire  = push_valid && push_ready;
  assign height     = height_q;

  always_ff @(posedge dclk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      height_q <= '0;
      for (int i = 0; i < DEPTH; i++) rows_q[i] <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          // clear outranks a push offered in the same cycle
          if (clear) begin
            state_q  <= ST_CLEARING;
            height_q <= '0;
            for (int i = 0; i < DEPTH; i++) rows_q[i] <= '0;
          end else if (push_fire) begin
            if (full) begin
              for (int i = 0; i < DEPTH-1; i++) rows_q[i] <= rows_q[i+1];
              rows_q[DEPTH-1] <= push_clr;
            end else begin
              for (int i = 0; i < DEPTH; i++)
                if (height_q == HW'(i)) rows_q[i] <= push_clr;
              height_q <= height_q + HW'(1);
            end
          end
        end
        ST_CLEARING: begin
          if (frame_start) state_q <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge dclk or negedge rst) begin
    if (!rst) begin
      shpos_q <= '0;
      for (int i = 0; i < DEPTH; i++) shadow_q[i] <= '0;
    end else if (frame_start) begin
      shpos_q <= pos_x;
      for (int i = 0; i < DEPTH; i++) shadow_q[i] <= rows_q[i];
    end
  end

  always_ff @(posedge dclk or negedge rst) begin
    if (!rst) begin
      x_q    <= '0;
      y_q    <= '0;
      fx_q   <= '0;
      fy_q   <= '0;
      fclr_q <= '0;
      rgb_q  <= '0;
    end else begin
      x_q    <= x;
      y_q    <= y;
      fx_q   <= fall_x;
      fy_q   <= fall_y;
      fclr_q <= fall_clr;
      rgb_q  <= rgb_d;
    end
  end

  logic             row_hit [DEPTH];
  logic [RGB_W-1:0] row_rgb [DEPTH];
  logic             fall_hit;
  logic [RGB_W-1:0] fall_rgb;

  // Row i sits BLK_H above row i-1; its lower y bound is BASE_Y - i*BLK_H.
  for (genvar i = 0; i < DEPTH; i++) begin : g_row
    localparam coord_t ROW_LO_Y = coord_t'(BASE_Y - i*BLK_H);
    block_hit #(.CLR_W(CLR_W), .BLK_W(BLK_W), .BLK_H(BLK_H)) u_row_hit (
      .x_i    (x_q),
      .y_i    (y_q),
      .lo_x_i ({1'b0, shpos_q}),
      .lo_y_i (ROW_LO_Y),
      .clr_i  (shadow_q[i]),
      .hit_o  (row_hit[i]),
      .rgb_o  (row_rgb[i])
    );
  end

  block_hit #(.CLR_W(CLR_W), .BLK_W(BLK_W), .BLK_H(BLK_H)) u_fall_hit (
    .x_i    (x_q),
    .y_i    (y_q),
    .lo_x_i ({1'b0, fx_q}),
    .lo_y_i ({1'b0, fy_q}),
    .clr_i  (fclr_q),
    .hit_o  (fall_hit),
    .rgb_o  (fall_rgb)
  );

  always_comb begin
    rgb_d = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (row_hit[i]) rgb_d = row_rgb[i];
    if (fall_hit) rgb_d = fall_rgb;
  end

  assign RED   = rgb_q[RGB_W-1 -: RED_W];
  assign GREEN = rgb_q[BLUE_W +: GREEN_W];
  assign BLUE  = rgb_q[BLUE_W-1:0];

endmodule

// File: tb/tb_stack_renderer.sv
// tb/tb_stack_renderer.sv - scoreboard bench: scroll instance (DEPTH 16) and blocking instance (DEPTH 4)
module tb_stack_renderer;

  logic       dclk = 1'b0;
  logic       rst;
  logic [9:0] x, y, pos_x, fall_x, fall_y;
  logic [1:0] fall_clr;
  logic       frame_start;
  logic       pv_a, pv_b, clear_a, clear_b;
  logic [1:0] pc_a, pc_b;
  logic       pr_a, pr_b, full_a, full_b;
  logic [4:0] h_a;
  logic [2:0] h_b;
  logic [2:0] r_a, g_a, r_b, g_b;
  logic [1:0] b_a, b_b;

  always #5 dclk = ~dclk;

  stack_renderer u_a (
    .dclk(dclk), .rst(rst), .x(x), .y(y), .frame_start(frame_start), .pos_x(pos_x),
    .push_valid(pv_a), .push_ready(pr_a), .push_clr(pc_a), .clear(clear_a),
    .fall_x(fall_x), .fall_y(fall_y), .fall_clr(fall_clr),
    .height(h_a), .full(full_a), .RED(r_a), .GREEN(g_a), .BLUE(b_a)
  );

  stack_renderer #(.DEPTH(4), .SCROLL(0)) u_b (
    .dclk(dclk), .rst(rst), .x(x), .y(y), .frame_start(frame_start), .pos_x(pos_x),
    .push_valid(pv_b), .push_ready(pr_b), .push_clr(pc_b), .clear(clear_b),
    .fall_x(fall_x), .fall_y(fall_y), .fall_clr(fall_clr),
    .height(h_b), .full(full_b), .RED(r_b), .GREEN(g_b), .BLUE(b_b)
  );

  localparam logic [7:0] K_R = 8'hE0;
  localparam logic [7:0] K_G = 8'h1C;
  localparam logic [7:0] K_B = 8'h03;
  localparam logic [7:0] K_0 = 8'h00;

  typedef struct { logic dut; logic [7:0] rgb; string name; } pix_exp_t;
  typedef struct { logic dut; logic [4:0] h; logic f; logic r; string name; } stat_exp_t;

  pix_exp_t  pix_q[$];
  stat_exp_t stat_q[$];
  pix_exp_t  pe;
  stat_exp_t se;

  int checks = 0;
  int passes = 0;

  logic       probe_v = 1'b0, probe_dut = 1'b0;
  logic [1:0] tag_v = 2'b00, tag_dut = 2'b00;
  logic       stat_v = 1'b0, stat_dut = 1'b0;
  logic [7:0] act_rgb;
  logic [6:0] act_stat;

  // Tags follow each probe through the same two-stage delay as the renderer.
  always @(posedge dclk) begin
    tag_v   <= {tag_v[0], probe_v};
    tag_dut <= {tag_dut[0], probe_dut};
  end

  always @(negedge dclk) begin
    if (tag_v[1]) begin
      checks++;
      act_rgb = tag_dut[1] ? {r_b, g_b, b_b} : {r_a, g_a, b_a};
      if (pix_q.size() == 0) begin
        $display("FAIL pixel_unexpected: rgb=%h with no expectation queued", act_rgb);
      end else begin
        pe = pix_q.pop_front();
        if (act_rgb === pe.rgb) passes++;
        else $display("FAIL %s: rgb got %h expected %h", pe.name, act_rgb, pe.rgb);
      end
    end
    if (stat_v) begin
      checks++;
      act_stat = stat_dut ? {2'b00, h_b, full_b, pr_b} : {h_a, full_a, pr_a};
      if (stat_q.size() == 0) begin
        $display("FAIL status_unexpected: status=%h with no expectation queued", act_stat);
      end else begin
        se = stat_q.pop_front();
        if (act_stat === {se.h, se.f, se.r}) passes++;
        else $display("FAIL %s: height/full/ready got %0d/%0b/%0b expected %0d/%0b/%0b",
                      se.name, act_stat[6:2], act_stat[1], act_stat[0], se.h, se.f, se.r);
      end
    end
  end

  task automatic tick();
    @(posedge dclk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic probe(input logic d, input int px, input int py, input logic [7:0] e, input string nm);
    pix_q.push_back('{dut: d, rgb: e, name: nm});
    x = px[9:0];
    y = py[9:0];
    probe_dut = d;
    probe_v = 1'b1;
    tick();
    probe_v = 1'b0;
  endtask

  task automatic stat(input logic d, input int h, input logic f, input logic r, input string nm);
    stat_q.push_back('{dut: d, h: h[4:0], f: f, r: r, name: nm});
    stat_dut = d;
    stat_v = 1'b1;
    tick();
    stat_v = 1'b0;
  endtask

  task automatic push(input logic d, input logic [1:0] c);
    if (d) begin pv_b = 1'b1; pc_b = c; end
    else   begin pv_a = 1'b1; pc_a = c; end
    tick();
    pv_a = 1'b0;
    pv_b = 1'b0;
  endtask

  task automatic frame();
    idle(3);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  logic [1:0] cols [17];

  initial begin
    rst = 1'b0; x = '0; y = '0; pos_x = 10'd260;
    fall_x = '0; fall_y = '0; fall_clr = 2'b00; frame_start = 1'b0;
    pv_a = 1'b0; pv_b = 1'b0; pc_a = '0; pc_b = '0; clear_a = 1'b0; clear_b = 1'b0;

    idle(3);
    stat(0, 0, 1'b0, 1'b1, "reset_a");
    stat(1, 0, 1'b0, 1'b1, "reset_b");
    rst = 1'b1;
    tick();
    probe(0, 300, 410, K_0, "reset_pixel");

    push(0, 2'b10); push(0, 2'b01); push(0, 2'b11);
    stat(0, 3, 1'b0, 1'b1, "three_pushes");
    probe(0, 300, 410, K_0, "before_first_frame");
    frame();
    probe(0, 300, 410, K_R, "row0_red");
    probe(0, 300, 390, K_G, "row1_green");
    probe(0, 300, 370, K_B, "row2_blue");
    probe(0, 300, 350, K_0, "row3_empty");
    probe(0, 260, 410, K_0, "left_edge_strict");
    probe(0, 261, 410, K_R, "left_edge_inside");
    probe(0, 359, 410, K_R, "right_edge_inside");
    probe(0, 360, 410, K_0, "right_edge_strict");
    probe(0, 300, 400, K_0, "row_seam_strict");
    probe(0, 300, 401, K_R, "row0_top_inside");
    probe(0, 300, 419, K_R, "row0_bottom_inside");
    probe(0, 300, 420, K_0, "row0_bottom_strict");

    push(0, 2'b10);
    probe(0, 300, 350, K_0, "mid_frame_no_tear");
    frame();
    probe(0, 300, 350, K_R, "after_frame_row3");
    stat(0, 4, 1'b0, 1'b1, "four_pushes");

    fall_x = 10'd280; fall_y = 10'd395; fall_clr = 2'b11;
    probe(0, 300, 410, K_B, "fall_over_row0");
    probe(0, 300, 398, K_B, "fall_over_row1");
    probe(0, 300, 395, K_G, "fall_top_strict");
    fall_clr = 2'b00;
    probe(0, 300, 410, K_R, "fall_suppressed");
    fall_x = 10'd1000; fall_clr = 2'b11;
    probe(0, 1010, 410, K_B, "fall_past_right_edge");
    probe(0, 5, 410, K_0, "fall_no_wrap");
    fall_clr = 2'b00;

    clear_a = 1'b1; pv_a = 1'b1; pc_a = 2'b01;
    tick();
    clear_a = 1'b0; pv_a = 1'b0;
    stat(0, 0, 1'b0, 1'b0, "clear_wins");
    probe(0, 300, 410, K_R, "clear_shadow_kept");
    idle(4);
    stat(0, 0, 1'b0, 1'b0, "clearing_held");
    frame();
    stat(0, 0, 1'b0, 1'b1, "clearing_exit");
    probe(0, 300, 410, K_0, "cleared_frame");

    for (int i = 0; i < 17; i++) cols[i] = 2'b11;
    cols[0] = 2'b01; cols[1] = 2'b10; cols[15] = 2'b10; cols[16] = 2'b01;
    for (int i = 0; i < 15; i++) push(0, cols[i]);
    stat(0, 15, 1'b0, 1'b1, "fifteen_not_full");
    push(0, cols[15]);
    stat(0, 16, 1'b1, 1'b1, "sixteen_full");
    push(0, cols[16]);
    stat(0, 16, 1'b1, 1'b1, "scroll_height");
    frame();
    probe(0, 300, 410, K_R, "scroll_row0_push2");
    probe(0, 300, 390, K_B, "scroll_row1_push3");
    probe(0, 300, 130, K_R, "scroll_row14_push16");
    probe(0, 300, 110, K_G, "scroll_row15_push17");
    probe(0, 300, 90,  K_0, "above_row15");

    push(1, 2'b10); push(1, 2'b00); push(1, 2'b11); push(1, 2'b10);
    stat(1, 4, 1'b1, 1'b0, "noscroll_full");
    push(1, 2'b01);
    stat(1, 4, 1'b1, 1'b0, "noscroll_blocked");
    frame();
    probe(1, 300, 410, K_R, "noscroll_row0");
    probe(1, 300, 390, K_0, "noscroll_empty_push");
    probe(1, 300, 370, K_B, "noscroll_row2");
    probe(1, 300, 350, K_R, "noscroll_row3_kept");

    idle(5);
    checks++;
    if (pix_q.size() == 0 && stat_q.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: %0d pixel and %0d status expectations left, required 0",
                  pix_q.size(), stat_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", passes, checks);
    $fatal(1);
  end

endmodule
